// File: rtl/fifo_reader_pkg.sv
// Reader-local sizing and the read-credit check.
package fifo_reader_pkg;

    import shared_pkg::*;

    // Buffer occupancy counts 0..READER_DEPTH
    localparam int OCC_W = $clog2(READER_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;

    // A new read may be issued only if every word already committed (buffered
    // plus in flight) still fits once this cycle's pop has left the buffer.
    function automatic logic has_credit(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [SUM_W-1:0] committed;
        logic [SUM_W-1:0] limit;
        committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        limit     = SUM_W'(READER_DEPTH) + {{OCC_W{1'b0}}, pop};
        return committed < limit;
    endfunction

endpackage

// File: rtl/shared_pkg.sv
// Constants shared between the FIFO and its reader.
package shared_pkg;

    localparam int FIFO_WIDTH   = 16;
    localparam int READER_DEPTH = 2;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the reader.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = shared_pkg::FIFO_WIDTH
);

    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    // Reader side: pulls from the FIFO, pushes the stream downstream
    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        output m_valid,
        input  m_ready,
        output m_data
    );

    // Environment side: the FIFO and the downstream consumer
    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        input  m_valid,
        output m_ready,
        input  m_data
    );

endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order output buffer; head entry is always the oldest word.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = shared_pkg::FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q,  occ_d;

    // Shift-style update: pops move tail into head, pushes land in the first free slot
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = data_in;
                end else begin
                    tail_d = data_in;
                end
                occ_d = occ_q + 1'b1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 1'b1;
            end
            2'b11: begin
                // Occupancy holds; with one word the newcomer becomes head directly
                if (occ_q == OCC_W'(1)) begin
                    head_d = data_in;
                end else begin
                    head_d = tail_q;
                    tail_d = data_in;
                end
            end
            default: ;
        endcase
    end

    // Buffer registers; contents are cleared so the stream reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO into a registered valid/ready stream, using
// credit-based reads so the 2-entry buffer can never overflow.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_reader_if.master        bus,
    output logic [CNT_WIDTH-1:0] drain_count,
    output logic                 err
);

    logic [OCC_W-1:0]      occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  m_valid;
    logic                  pop;
    logic                  push;
    logic                  rd_en;

    logic                  inflight_q, inflight_d;
    logic                  err_q,      err_d;
    logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & bus.m_ready;
    // A returning word is kept only if the FIFO did not flag the read as empty
    assign push    = inflight_q & ~bus.fifo_underflow;
    // Reset gates the request directly so no read escapes while rst is high
    assign rd_en   = ~rst & en & ~bus.fifo_empty & has_credit(occ, inflight_q, pop);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head;
    assign drain_count    = cnt_q;
    assign err            = err_q;

    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .data_in (bus.fifo_data_out),
        .head    (head),
        .occ     (occ)
    );

    // Next state for in-flight tracking, sticky error and delivered-word counter
    always_comb begin
        inflight_d = rd_en;
        err_d      = err_q | (inflight_q & bus.fifo_underflow);
        cnt_d      = cnt_q + CNT_WIDTH'(pop);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
